apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
- APB completer that answers transfers from the team's APB master FSM (IDLE/SETUP/ENABLE sequencing).
- Decodes the 8-bit PADDR into a word-addressed 32-bit register bank.
- Inserts a programmable number of wait states through PREADY, and flags illegal accesses on PSLVERR.
- Sits on the peripheral side of the APB bus as the reference target for master bring-up and verification.

Parameters:
- NUM_REGS, 16, number of 32-bit registers. Legal range 2..64; register index = PADDR[7:2].
- WAIT_CYCLES, 2, wait states inserted in each access phase. Legal range 0..15.
- ID_VALUE, 32'hA0B1_0001, constant returned by register 0, which is read-only.

Ports:
- PCLK  input  1  bus clock; all state changes on the rising edge.
- PRESETn  input  1  reset.
- PSEL  input  1  slave select from master.
- PENABLE  input  1  access-phase indicator from master.
- PWRITE  input  1  1 = write, 0 = read; sampled in the setup phase.
- PADDR  input  8  byte address; sampled in the setup phase.
- PWDATA  input  32  write data; sampled on the completing cycle.
- PREADY  output  1  transfer completes in a cycle where PSEL & PENABLE & PREADY.
- PRDATA  output  32  read data; valid only when PREADY=1 on a read.
- PSLVERR  output  1  error response; valid only when PREADY=1.

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK.
  - While PRESETn=0: FSM = IDLE, wait counter = 0, registers 1..NUM_REGS-1 = 0, PREADY = 0, PRDATA = 0, PSLVERR = 0.
  - Reset asserted mid-transfer aborts the transfer with no register update.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - PREADY = 0.
  - On PSEL=1 & PENABLE=0 (setup phase), latch PADDR, PWRITE and the error flag, clear the counter, and go to ACCESS.
  - PENABLE=1 seen in IDLE without a prior setup phase is ignored.
- ACCESS:
  - Counter increments by 1 each cycle while below WAIT_CYCLES, then saturates.
  - PREADY = (counter == WAIT_CYCLES). PREADY is decoded from registered state only, with no combinational path from bus inputs.
  - The access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
  - On the cycle with PSEL & PENABLE & PREADY, the transfer completes and the FSM returns to IDLE.
  - Back-to-back transfers are supported: the setup phase in the cycle after completion is accepted normally.
- Master abort: if PSEL=0 while in ACCESS, go to IDLE immediately. No write, no response, counter cleared.
- Error decode, latched in the setup phase:
  - err = (PADDR[1:0] != 0) | (PADDR[7:2] >= NUM_REGS) | (PWRITE & PADDR[7:2] == 0).
- Write:
  - On the completing cycle, if !err, reg[PADDR[7:2]] <= PWDATA.
  - An erroring write leaves all registers unchanged.
- Read:
  - PRDATA = reg[idx] (register 0 returns ID_VALUE) only while PREADY=1, the latched PWRITE=0 and !err.
  - Otherwise PRDATA = 0, including during error responses.
- PSLVERR = PREADY & err; it is 0 at all other times.
- Changes of PADDR, PWRITE or PWDATA during the access phase do not alter the latched address or direction. PWDATA is taken from the completing cycle.

Test Plan:
- Reset then idle: PRESETn low for 3 cycles, then high with PSEL=0 -> PREADY=0, PRDATA=0, PSLVERR=0, and a later read of 0x04 returns 0.
- Write then read, default WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x08 -> PREADY high on the 3rd access cycle, PSLVERR=0.
  - Read 0x08 -> PRDATA=0xDEADBEEF on the completing cycle, 0 before it.
- ID register and read-only protection:
  - Read 0x00 -> 0xA0B10001.
  - Write 0x12345678 to 0x00 -> PSLVERR=1 on the completing cycle; re-read still returns 0xA0B10001.
- Illegal addresses:
  - Read 0x41 (misaligned) -> PSLVERR=1, PRDATA=0.
  - Write to 0x40 (index 16, out of range) -> PSLVERR=1, no register changes.
- Back-to-back with WAIT_CYCLES=0: write 0x11 to 0x04, then a setup phase in the very next cycle reading 0x04 -> each transfer is 2 cycles, PREADY=1 on the first access cycle, read returns 0x11.
- Abort and reset mid-transfer:
  - PSEL dropped on the 2nd access cycle of a write of 0xFF to 0x0C -> reg3 keeps its old value, PREADY never asserts.
  - PRESETn pulsed low during a write access phase -> outputs 0 immediately and reg3 = 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer: word-addressed bank of 32-bit registers with programmable wait states.
// Register 0 is a read-only ID. Misaligned, out-of-range and read-only accesses get PSLVERR.
module apb_slave_regfile #(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA0B1_0001
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic        PREADY,
   output logic [31:0] PRDATA,
   output logic        PSLVERR
);

   localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0]  WAIT_C   = 4'(WAIT_CYCLES);
   localparam logic [6:0]  NUM_C    = 7'(NUM_REGS);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [3:0]         r_cnt;
   logic [3:0]         w_next_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_write;
   logic               r_err;
   logic [31:0]        r_regs [NUM_REGS];

   logic               w_accept;
   logic               w_wr_en;
   logic               w_ready;
   logic               w_setup_err;
   logic [31:0]        w_rdata_sel;

   // Error is decided once, from the setup-phase address and direction.
   assign w_setup_err = (PADDR[1:0] != 2'b00)
                     || ({1'b0, PADDR[7:2]} >= NUM_C)
                     || (PWRITE && (PADDR[7:2] == 6'd0));

   assign w_ready = (r_state == S_ACCESS) && (r_cnt == WAIT_C);

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_accept     = 1'b0;
      w_wr_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               w_next_state = S_ACCESS;
               w_next_cnt   = '0;
               w_accept     = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!PSEL) begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else if (PENABLE && w_ready) begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
               w_wr_en      = r_write && !r_err;
            end else if (r_cnt != WAIT_C) begin
               w_next_cnt = r_cnt + 4'd1;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_idx   <= PADDR[2 +: IDX_W];
            r_write <= PWRITE;
            r_err   <= w_setup_err;
         end
      end
   end

   // NOTE: the bank is reset because software relies on registers reading 0 after reset.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[r_idx] <= PWDATA;
      end
   end

   assign w_rdata_sel = (r_idx == '0) ? ID_VALUE : r_regs[r_idx];

   assign PREADY  = w_ready;
   assign PSLVERR = w_ready && r_err;
   assign PRDATA  = (w_ready && !r_write && !r_err) ? w_rdata_sel : '0;

endmodule
